clk_div_seq: RTL

Sequencer and arbiter for the reference clock divider's configuration inputs. Two requesters (A, B) submit divide-ratio changes over valid/ready handshakes. The block round-robin arbitrates between them and drives the divider's ratio and clock-enable with a safe sequence: gate, load, re-enable, settle. It completes each change with a done or error pulse, so only one ratio change is ever in flight.

---
 rtl/clk_div_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/clk_div_seq.sv
// Sequencer/arbiter that applies divide-ratio changes from two requesters using a gate/load/settle sequence.
// Optional macro DIV_SEQ_RATIO_CHECK_EN rejects ratios below 2 with an o_err pulse.
module clk_div_seq #(
  parameter int WIDTH       = 5,
  parameter int GATE_CYCLES = 4,
  parameter int RESET_RATIO = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_req_a_valid,
  input  logic [WIDTH-1:0] i_req_a_ratio,
  output logic             o_req_a_ready,
  input  logic             i_req_b_valid,
  input  logic [WIDTH-1:0] i_req_b_ratio,
  output logic             o_req_b_ready,
  output logic [WIDTH-1:0] o_div_ratio,
  output logic             o_clk_en,
  output logic             o_busy,
  output logic             o_grant_id,
  output logic             o_done,
  output logic             o_err
);

  localparam int GW = $clog2(GATE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATE   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
`ifdef DIV_SEQ_RATIO_CHECK_EN
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
`else
    S_DONE   = 3'd4
`endif
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               ptr_r;
  logic [WIDTH-1:0]   ratio_r;
  logic [GW-1:0]      gate_cnt_r;
  logic [WIDTH:0]     settle_cnt_r;
  logic [WIDTH-1:0]   div_ratio_r;
  logic               clk_en_r;
  logic               busy_r;
  logic               grant_id_r;
  logic               done_r;
  logic               grant_a_s;
  logic               grant_b_s;
  logic               hs_s;
  logic [WIDTH-1:0]   hs_ratio_s;
  logic [WIDTH:0]     settle_load_s;

  // Round-robin arbitration, handshake detection and next-state logic
  always_comb begin
    grant_a_s     = i_req_a_valid & (~i_req_b_valid | ~ptr_r);
    grant_b_s     = i_req_b_valid & (~i_req_a_valid | ptr_r);
    hs_s          = (state_r == S_IDLE) & (grant_a_s | grant_b_s);
    hs_ratio_s    = i_req_b_ratio;
    settle_load_s = {ratio_r, 1'b0};
    next_state_s  = state_r;
    if (grant_a_s) begin
      hs_ratio_s = i_req_a_ratio;
    end else begin
      hs_ratio_s = i_req_b_ratio;
    end
    // Two divided periods, never fewer than 2 cycles for ratios 0/1
    if (ratio_r < WIDTH'(2)) begin
      settle_load_s = (WIDTH+1)'(2);
    end else begin
      settle_load_s = {ratio_r, 1'b0};
    end
    case (state_r)
      S_IDLE: begin
        if (hs_s) begin
`ifdef DIV_SEQ_RATIO_CHECK_EN
          if (hs_ratio_s < WIDTH'(2)) begin
            next_state_s = S_ERR;
          end else begin
            next_state_s = S_GATE;
          end
`else
          next_state_s = S_GATE;
`endif
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_GATE: begin
        if (gate_cnt_r == GW'(1)) begin
          next_state_s = S_LOAD;
        end else begin
          next_state_s = S_GATE;
        end
      end
      S_LOAD:   next_state_s = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt_r == (WIDTH+1)'(1)) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_SETTLE;
        end
      end
      S_DONE:   next_state_s = S_IDLE;
`ifdef DIV_SEQ_RATIO_CHECK_EN
      S_ERR:    next_state_s = S_IDLE;
`endif
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Ready is only offered in IDLE to the arbitration winner
  always_comb begin
    o_req_a_ready = (state_r == S_IDLE) & grant_a_s;
    o_req_b_ready = (state_r == S_IDLE) & grant_b_s;
  end

  // State, counters and registered divider controls
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      ptr_r        <= 1'b0;
      ratio_r      <= WIDTH'(RESET_RATIO);
      gate_cnt_r   <= '0;
      settle_cnt_r <= '0;
      div_ratio_r  <= WIDTH'(RESET_RATIO);
      clk_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      grant_id_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != S_IDLE);
      done_r  <= (next_state_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (hs_s) begin
            ratio_r    <= hs_ratio_s;
            grant_id_r <= grant_b_s;
            ptr_r      <= ~grant_b_s;
            gate_cnt_r <= GW'(GATE_CYCLES);
          end else begin
            ratio_r <= ratio_r;
          end
          // A rejected request leaves the clock enable untouched
          if (next_state_s == S_GATE) begin
            clk_en_r <= 1'b0;
          end else begin
            clk_en_r <= clk_en_r;
          end
        end
        S_GATE: gate_cnt_r <= gate_cnt_r - GW'(1);
        S_LOAD: begin
          div_ratio_r  <= ratio_r;
          settle_cnt_r <= settle_load_s;
          clk_en_r     <= 1'b1;
        end
        S_SETTLE: settle_cnt_r <= settle_cnt_r - (WIDTH+1)'(1);
        default: clk_en_r <= clk_en_r;
      endcase
    end
  end

`ifdef DIV_SEQ_RATIO_CHECK_EN
  logic err_r;

  // Single-cycle rejection pulse
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (next_state_s == S_ERR);
    end
  end

  assign o_err = err_r;
`else
  assign o_err = 1'b0;
`endif

  assign o_div_ratio = div_ratio_r;
  assign o_clk_en    = clk_en_r;
  assign o_busy      = busy_r;
  assign o_grant_id  = grant_id_r;
  assign o_done      = done_r;

endmodule
